// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation and sequencer state encodings
package alu_pkg;
    typedef enum logic [1:0] {ADD = 2'd0, AND = 2'd1, OR = 2'd2, XOR = 2'd3} operation;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;
endpackage

// File: rtl/alu_param.sv
// alu_param: combinational W-bit ALU with carry-in and N/Z/V/C flags
module alu_param
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  operation     op_i,
    input  logic         cin_i,
    output logic [W-1:0] res_o,
    output logic         cout_o,
    output logic         n_o,
    output logic         z_o,
    output logic         v_o
);
    logic [W:0] sum;
    assign sum    = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign res_o  = op_i == ADD ? sum[W-1:0] : op_i == AND ? a_i & b_i : op_i == OR ? a_i | b_i : a_i ^ b_i;
    assign cout_o = op_i == ADD && sum[W];
    assign v_o    = op_i == ADD && a_i[W-1] == b_i[W-1] && sum[W-1] != a_i[W-1];
    assign n_o    = res_o[W-1];
    assign z_o    = res_o == '0;
endmodule

// File: rtl/mp_alu_seq.sv
// mp_alu_seq: limb-serial multi-precision ALU sequencer; MP_ALU_SEQ_CNT_EN adds the ops_done counter
module mp_alu_seq
    import alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int LIMBS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*LIMBS-1:0] in_a,
    input  logic [W*LIMBS-1:0] in_b,
    input  operation           in_op,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*LIMBS-1:0] out_res,
    output logic               out_cout,
    output logic               out_n,
    output logic               out_z,
    output logic               out_v
`ifdef MP_ALU_SEQ_CNT_EN
    ,
    output logic [15:0]        ops_done
`endif
);
    localparam int N  = W * LIMBS;
    localparam int IW = $clog2(LIMBS);
    localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);
    mp_state_t     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cy_q, cy_d, za_q, za_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    operation      op_q, op_d;
    logic          cout_q, cout_d, n_q, n_d, z_q, z_d, v_q, v_d;
    logic [W-1:0]  alu_res;
    logic          alu_cout, alu_n, alu_z, alu_v;
    alu_param #(.W(W)) u_alu (
        .a_i   (a_q[int'(idx_q)*W +: W]),
        .b_i   (b_q[int'(idx_q)*W +: W]),
        .op_i  (op_q),
        .cin_i (cy_q),
        .res_o (alu_res),
        .cout_o(alu_cout),
        .n_o   (alu_n),
        .z_o   (alu_z),
        .v_o   (alu_v)
    );
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_res   = res_q;
    assign out_cout  = cout_q;
    assign out_n     = n_q;
    assign out_z     = z_q;
    assign out_v     = v_q;
    // next state: capture in IDLE, one limb per RUN cycle, publish the whole word when leaving RUN
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        za_d    = za_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                a_d     = in_a;
                b_d     = in_b;
                op_d    = in_op;
                cy_d    = in_cin;
                idx_d   = '0;
                za_d    = 1'b1;
            end
            RUN: begin
                acc_d[int'(idx_q)*W +: W] = alu_res;
                cy_d  = alu_cout;
                za_d  = za_q & alu_z;
                idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    res_d   = acc_d;
                    cout_d  = alu_cout;
                    n_d     = alu_n;
                    v_d     = alu_v;
                    z_d     = za_q & alu_z;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            za_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ADD;
            acc_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            za_q    <= za_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end
`ifdef MP_ALU_SEQ_CNT_EN
    logic [15:0] cnt_q;
    // count result handshakes, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else if (out_valid && out_ready && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
    end
    assign ops_done = cnt_q;
`endif
endmodule

// File: tb/tb_mp_alu_seq.sv
// tb_mp_alu_seq: scoreboard bench for mp_alu_seq (W=8, LIMBS=4)
module tb_mp_alu_seq;
    import alu_pkg::*;
    localparam int W = 8;
    localparam int L = 4;
    localparam int N = W * L;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    operation     in_op = ADD;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_res;
    logic         out_cout, out_n, out_z, out_v;
`ifdef MP_ALU_SEQ_CNT_EN
    logic [15:0]  ops_done;
`endif
    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0;
    typedef struct packed {
        logic [N-1:0] res;
        logic c, n, z, v;
    } exp_t;
    exp_t sb[$];

    mp_alu_seq #(.W(W), .LIMBS(L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_cout (out_cout),
        .out_n    (out_n),
        .out_z    (out_z),
        .out_v    (out_v)
`ifdef MP_ALU_SEQ_CNT_EN
        ,
        .ops_done (ops_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input operation op, input logic cin);
        logic [N:0] s;
        exp_t e;
        e = '0;
        case (op)
            ADD: begin
                s     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                e.res = s[N-1:0];
                e.c   = s[N];
                e.v   = (a[N-1] == b[N-1]) && (e.res[N-1] != a[N-1]);
            end
            AND: e.res = a & b;
            OR:  e.res = a | b;
            default: e.res = a ^ b;
        endcase
        e.n = e.res[N-1];
        e.z = e.res == '0;
        return e;
    endfunction

    // called #1 after a rising edge; returns #1 after the accepting edge
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input operation op, input logic cin, input bit push);
        int k = 0;
        in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(model(a, b, op, cin));
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_op = operation'($urandom_range(0, 3));
        in_cin = 1'(($urandom));
    endtask

    task automatic collect(input int hold, input int exp_lat, input logic keep_valid);
        int k = 0;
        exp_t e, snap;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!out_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        if (exp_lat >= 0) check("latency", k, exp_lat);
        snap = {out_res, out_cout, out_n, out_z, out_v};
        for (int i = 0; i < hold; i++) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_stable", {out_res, out_cout, out_n, out_z, out_v}, snap);
        end
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("res", out_res, e.res);
        check("cout", out_cout, e.c);
        check("n", out_n, e.n);
        check("z", out_z, e.z);
        check("v", out_v, e.v);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_done++;
        check("ack_valid", out_valid, 0);
        check("idle_ready", in_ready, 1);
        check("idle_hold", {out_res, out_cout, out_n, out_z, out_v}, {e.res, e.c, e.n, e.z, e.v});
        if (keep_valid) in_valid = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_flags", {out_cout, out_n, out_z, out_v}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(32'h000000FF, 32'h00000001, ADD, 1'b0, 1); collect(0, 4, 0);
        drive(32'hFFFFFFFF, 32'h00000000, ADD, 1'b1, 1); collect(0, 4, 0);
        drive(32'h7FFFFFFF, 32'h00000001, ADD, 1'b0, 1); collect(0, 4, 0);
        drive(32'hA5A5A5A5, 32'hA5A5A5A5, XOR, 1'b1, 1); collect(0, 4, 0);
        drive(32'h00F0000F, 32'h0F000000, OR,  1'b0, 1); collect(0, 4, 0);
        drive(32'hF0F0FF00, 32'h3C3CF0F0, AND, 1'b1, 1); collect(0, 4, 0);
        drive(32'h80000000, 32'h80000000, ADD, 1'b0, 1); collect(0, 4, 0);
        for (int i = 0; i < 6; i++) begin
            drive({$urandom}, {$urandom}, operation'($urandom_range(0, 3)), 1'(($urandom)), 1);
            collect(0, 4, 0);
        end
        drive(32'h12345678, 32'h11111111, ADD, 1'b0, 1);
        in_a = 32'hDEADBEEF; in_b = 32'h01020304; in_op = XOR; in_cin = 1'b0; in_valid = 1'b1;
        collect(3, -1, 1);
        drive(32'hDEADBEEF, 32'h01020304, XOR, 1'b0, 1);
        collect(0, 4, 0);
        drive(32'h01010101, 32'h01010101, ADD, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_out_res", out_res, 0);
        check("midrun_rst_flags", {out_cout, out_n, out_z, out_v}, 0);
        n_done = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 0);
        drive(32'h00000001, 32'h00000001, ADD, 1'b0, 1); collect(0, 4, 0);
`ifdef MP_ALU_SEQ_CNT_EN
        check("ops_done", ops_done, n_done);
`endif
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
